// File: rtl/intack_pkg.sv
// rtl/intack_pkg.sv - shared types and constants for the interrupt acknowledge sequencer
package intack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK_LOW = 3'd1,
        ACK_GAP = 3'd2,
        DONE    = 3'd3,
        HOLDOFF = 3'd4
    } intack_state_e;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;
    localparam int PULSES_8086 = 2;
    localparam int PULSES_8080 = 3;

    function automatic logic [1:0] last_pulse_index(input logic is_8086);
        return is_8086 ? 2'(PULSES_8086 - 1) : 2'(PULSES_8080 - 1);
    endfunction

endpackage

// File: rtl/intack_pulse_timer.sv
// rtl/intack_pulse_timer.sv - loadable down-counter timing the INTA# low and gap phases
module intack_pulse_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal_count
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so a phase that outlives its load never wraps.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign terminal_count = (count == '0);

endmodule

// File: rtl/cpu_interrupt_acknowledge_sequencer.sv
// rtl/cpu_interrupt_acknowledge_sequencer.sv - CPU-side 8259A INTA# pulse train initiator
module cpu_interrupt_acknowledge_sequencer
    import intack_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        interrupt_to_cpu,
    input  logic        interrupt_enable,
    input  logic        mode_8086,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    output logic [7:0]  vector_8086,
    output logic [15:0] call_address,
    output logic        opcode_error
);

    localparam int MAX_CYCLES = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);

    intack_state_e state, state_next;
    logic          mode_q;
    logic [1:0]    pulse_index;
    logic [7:0]    byte0, byte1;
    logic          phase_done;
    logic          last_pulse;

    assign last_pulse = (pulse_index == last_pulse_index(mode_q));

    intack_pulse_timer #(.WIDTH(CW)) u_timer (
        .clock          (clock),
        .reset_n        (reset_n),
        .load           (state_next != state),
        .load_value     ((state_next == ACK_GAP) ? GAP_LOAD : LOW_LOAD),
        .terminal_count (phase_done)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (interrupt_to_cpu && interrupt_enable) state_next = ACK_LOW;
            ACK_LOW: if (phase_done) state_next = last_pulse ? DONE : ACK_GAP;
            ACK_GAP: if (phase_done) state_next = ACK_LOW;
            DONE:    state_next = HOLDOFF;
            HOLDOFF: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == ACK_LOW) || (state == ACK_GAP) || (state == DONE);
        vector_valid = (state == DONE);
    end

    // INTA# is registered from the next state so the pin never glitches off inputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            interrupt_acknowledge_n <= 1'b1;
            mode_q                  <= 1'b0;
            pulse_index             <= 2'd0;
            byte0                   <= 8'd0;
            byte1                   <= 8'd0;
            vector_8086             <= 8'd0;
            call_address            <= 16'd0;
            opcode_error            <= 1'b0;
        end else begin
            interrupt_acknowledge_n <= (state_next != ACK_LOW);
            if (state == IDLE && state_next == ACK_LOW) begin
                mode_q      <= mode_8086;
                pulse_index <= 2'd0;
            end
            if (state == ACK_GAP && state_next == ACK_LOW) begin
                pulse_index <= pulse_index + 2'd1;
            end
            if (state == ACK_LOW && phase_done) begin
                case (pulse_index)
                    2'd0:    byte0 <= data_bus_in;
                    2'd1:    byte1 <= data_bus_in;
                    default: ;
                endcase
            end
            // The final byte is taken straight off the bus on the edge entering DONE.
            if (state == ACK_LOW && state_next == DONE) begin
                if (mode_q) begin
                    vector_8086 <= data_bus_in;
                end else begin
                    call_address <= {data_bus_in, byte1};
                    opcode_error <= (byte0 != CALL_OPCODE);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_interrupt_acknowledge_sequencer.sv
// tb/tb_cpu_interrupt_acknowledge_sequencer.sv - self-checking bench for the INTA# sequencer
module tb_cpu_interrupt_acknowledge_sequencer;

    localparam int L = 2;
    localparam int G = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        interrupt_to_cpu;
    logic        interrupt_enable;
    logic        mode_8086;
    logic [7:0]  data_bus_in;
    logic        interrupt_acknowledge_n;
    logic        busy;
    logic        vector_valid;
    logic [7:0]  vector_8086;
    logic [15:0] call_address;
    logic        opcode_error;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [7:0]  exp_vec  = 8'd0;
    logic [15:0] exp_call = 16'd0;
    logic        exp_err  = 1'b0;

    cpu_interrupt_acknowledge_sequencer #(
        .INTA_LOW_CYCLES (L),
        .INTA_GAP_CYCLES (G)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .interrupt_to_cpu        (interrupt_to_cpu),
        .interrupt_enable        (interrupt_enable),
        .mode_8086               (mode_8086),
        .data_bus_in             (data_bus_in),
        .interrupt_acknowledge_n (interrupt_acknowledge_n),
        .busy                    (busy),
        .vector_valid            (vector_valid),
        .vector_8086             (vector_8086),
        .call_address            (call_address),
        .opcode_error            (opcode_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total = checks_total + 1;
        assert (obs === exp) checks_passed = checks_passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check16(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    task automatic check_results(input string tag);
        check16({tag, "_vector"}, {8'd0, vector_8086}, {8'd0, exp_vec});
        check16({tag, "_call"}, call_address, exp_call);
        check1({tag, "_opcode_error"}, opcode_error, exp_err);
    endtask

    // Cycle k (1-based) after the start edge lies inside an INTA# low window?
    function automatic bit exp_low(input int k);
        int r;
        r = (k - 1) % (L + G);
        return r < L;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check1("idle_inta_n", interrupt_acknowledge_n, 1'b1);
            check1("idle_busy", busy, 1'b0);
            check1("idle_vector_valid", vector_valid, 1'b0);
            interrupt_to_cpu = 1'($urandom);
            interrupt_enable = interrupt_to_cpu ? 1'b0 : 1'($urandom);
            mode_8086        = 1'($urandom);
            data_bus_in      = 8'($urandom);
        end
    endtask

    // Caller guarantees the DUT is idle; the start edge is the next rising edge.
    task automatic run_seq(input logic m, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input bit drop_int, input bit wiggle,
                           input bit hold);
        logic [7:0] bytes [3];
        int n;
        int d;
        int p;
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        n = m ? 2 : 3;
        d = n * L + (n - 1) * G + 1;
        interrupt_to_cpu = 1'b1;
        interrupt_enable = 1'b1;
        mode_8086        = m;
        data_bus_in      = 8'($urandom);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clock);
            if (k < d) begin
                check1("seq_inta_n", interrupt_acknowledge_n, exp_low(k) ? 1'b0 : 1'b1);
                check1("seq_busy", busy, 1'b1);
                check1("seq_vector_valid_early", vector_valid, 1'b0);
            end else if (k == d) begin
                if (m) begin
                    exp_vec = b1;
                end else begin
                    exp_call = {b2, b1};
                    exp_err  = (b0 != 8'hCD);
                end
                check1("done_inta_n", interrupt_acknowledge_n, 1'b1);
                check1("done_busy", busy, 1'b1);
                check1("done_vector_valid", vector_valid, 1'b1);
                check_results("done");
            end else begin
                check1("holdoff_inta_n", interrupt_acknowledge_n, 1'b1);
                check1("holdoff_busy", busy, 1'b0);
                check1("holdoff_vector_valid", vector_valid, 1'b0);
                check_results("holdoff");
            end
            p = (k - 1) / (L + G);
            if (k < d && exp_low(k) && ((k - 1) % (L + G)) == L - 1) begin
                data_bus_in = bytes[p];
            end else begin
                data_bus_in = 8'($urandom);
            end
            if (drop_int && k > L) interrupt_to_cpu = 1'b0;
            if (wiggle) begin
                mode_8086        = 1'($urandom);
                interrupt_enable = 1'($urandom);
            end
            if (k == d + 1) begin
                interrupt_to_cpu = hold;
                interrupt_enable = 1'b1;
            end
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        interrupt_to_cpu = 1'b0;
        interrupt_enable = 1'b0;
        mode_8086        = 1'b0;
        data_bus_in      = 8'd0;
        repeat (3) @(negedge clock);
        check1("reset_inta_n", interrupt_acknowledge_n, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_vector_valid", vector_valid, 1'b0);
        check_results("reset");
        reset_n = 1'b1;
        idle_cycles(2);

        run_seq(1'b1, 8'h11, 8'h48, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        run_seq(1'b0, 8'hCD, 8'h40, 8'h12, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        run_seq(1'b0, 8'h00, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);

        interrupt_to_cpu = 1'b1;
        interrupt_enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check1("masked_inta_n", interrupt_acknowledge_n, 1'b1);
            check1("masked_busy", busy, 1'b0);
        end
        run_seq(1'b1, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);

        interrupt_to_cpu = 1'b1;
        interrupt_enable = 1'b1;
        mode_8086        = 1'b1;
        data_bus_in      = 8'h77;
        for (int k = 1; k <= L + G + L; k++) begin
            @(negedge clock);
            check1("prereset_inta_n", interrupt_acknowledge_n, exp_low(k) ? 1'b0 : 1'b1);
            check1("prereset_busy", busy, 1'b1);
            if (k == L + G + L) reset_n = 1'b0;
        end
        @(negedge clock);
        exp_vec  = 8'd0;
        exp_call = 16'd0;
        exp_err  = 1'b0;
        check1("midreset_inta_n", interrupt_acknowledge_n, 1'b1);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_vector_valid", vector_valid, 1'b0);
        check_results("midreset");
        reset_n          = 1'b1;
        interrupt_to_cpu = 1'b0;
        idle_cycles(3);

        run_seq(1'b1, 8'h00, 8'h99, 8'h00, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        check1("rearm_idle_inta_n", interrupt_acknowledge_n, 1'b1);
        check1("rearm_idle_busy", busy, 1'b0);
        run_seq(1'b0, 8'hCD, 8'hEF, 8'hBE, 1'b1, 1'b1, 1'b0);
        idle_cycles(1);

        for (int s = 0; s < 30; s++) begin
            logic       m;
            logic [7:0] b0;
            m  = 1'($urandom);
            b0 = ($urandom_range(0, 1) == 0) ? 8'hCD : 8'($urandom);
            run_seq(m, b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            idle_cycles($urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/cpu_interrupt_acknowledge_sequencer.md
Name: cpu_interrupt_acknowledge_sequencer

Overview:
CPU-side initiator of the 8259A interrupt acknowledge protocol, used by bench and system models that sit opposite the controller. It detects interrupt_to_cpu, drives the INTA# pulse train: two pulses in 8086 mode, three in 8080/85 mode. It captures the bytes the controller places on the data bus and presents the resulting vector or CALL address with a one-cycle valid strobe.

Parameters:
INTA_LOW_CYCLES, 2, cycles per INTA# low pulse (>=1)
INTA_GAP_CYCLES, 2, cycles INTA# held high between pulses (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
interrupt_to_cpu  input  1  INT from controller, active high
interrupt_enable  input  1  CPU IF flag; sequence starts only when high
mode_8086  input  1  1 = 8086 (2 pulses), 0 = 8080/85 (3 pulses)
data_bus_in  input  8  controller data bus during INTA#
interrupt_acknowledge_n  output  1  INTA# to controller, active low
busy  output  1  high while a sequence is in progress
vector_valid  output  1  one-cycle strobe: result registers updated
vector_8086  output  8  vector byte from 2nd pulse (8086 mode)
call_address  output  16  {3rd byte, 2nd byte} (8080 mode)
opcode_error  output  1  8080 mode: 1st byte != 8'hCD

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clock edge).
- Reset values: interrupt_acknowledge_n=1, busy=0, vector_valid=0, vector_8086=0, call_address=0, opcode_error=0, state IDLE, counters 0.
- Reset has priority over everything. Asserting reset mid-pulse forces interrupt_acknowledge_n high at that same edge, discards any partial capture, and returns the block to IDLE.
- States: IDLE, ACK_LOW, ACK_GAP, DONE, HOLDOFF.
- IDLE: interrupt_to_cpu=1 and interrupt_enable=1 at an edge -> ACK_LOW. At that edge:
  - mode_8086 is latched for the whole sequence; later changes are ignored.
  - The pulse index is cleared.
  - interrupt_acknowledge_n goes low.
- ACK_LOW: interrupt_acknowledge_n=0 for exactly INTA_LOW_CYCLES cycles.
  - data_bus_in is captured at the edge ending the last low cycle, the same edge where interrupt_acknowledge_n returns high.
  - Capture slot = pulse index 0/1/2.
  - Then: ACK_GAP if pulses remain (2 total in 8086 mode, 3 in 8080 mode); otherwise DONE.
- ACK_GAP: interrupt_acknowledge_n=1 for exactly INTA_GAP_CYCLES cycles; pulse index increments; then ACK_LOW.
- DONE (1 cycle): vector_valid=1. Result registers take the new values on the edge entering DONE and hold until the next DONE.
  - 8086 mode: vector_8086 = byte1; byte0 is ignored; call_address and opcode_error are unchanged.
  - 8080 mode: call_address = {byte2, byte1}; opcode_error = (byte0 != 8'hCD); vector_8086 is unchanged.
- HOLDOFF (1 cycle): then IDLE. This guarantees at least one cycle with INT re-sampled before a new sequence, so a re-asserted INT starts a fresh sequence no earlier than 2 cycles after vector_valid.
- busy=1 in ACK_LOW, ACK_GAP and DONE; 0 in IDLE and HOLDOFF.
- interrupt_to_cpu or interrupt_enable dropping mid-sequence does not abort; the full pulse train completes (the controller is frozen during acknowledge).
- Latency, IDLE start edge to vector_valid high:
  - 8086: 2*INTA_LOW_CYCLES + INTA_GAP_CYCLES + 1 cycles.
  - 8080: 3*INTA_LOW_CYCLES + 2*INTA_GAP_CYCLES + 1 cycles.
- Counter widths: $clog2 of max(INTA_LOW_CYCLES, INTA_GAP_CYCLES)+1; the counter reloads on every state entry with no wrap-around.
- interrupt_acknowledge_n is driven directly from a flop; it has no combinational path from inputs.

Decomposition:
- Shared package intack_pkg:
  - state enum/localparams IDLE=3'd0, ACK_LOW=3'd1, ACK_GAP=3'd2, DONE=3'd3, HOLDOFF=3'd4
  - CALL_OPCODE=8'hCD
  - PULSES_8086=2, PULSES_8080=3
- One natural sub-module: intack_pulse_timer, a loadable down-counter with a terminal-count flag, shared by the low and gap phases.

Test Plan (INTA_LOW_CYCLES=2, INTA_GAP_CYCLES=2):
- 8086 mode, INT=1, enable=1, bus=8'h48 during 2nd pulse -> two 2-cycle INTA# lows separated by 2 high cycles; vector_valid at cycle 7; vector_8086=8'h48; call_address unchanged.
- 8080 mode, bus bytes CD/40/12 on pulses 1/2/3 -> three pulses; vector_valid at cycle 11; call_address=16'h1240; opcode_error=0.
- 8080 mode, first byte 8'h00 -> opcode_error=1; call_address still updated from bytes 2/3.
- INT=1, enable=0 for 20 cycles -> interrupt_acknowledge_n stays 1, busy=0; enable=1 -> sequence starts at the next edge.
- reset_n=0 during 2nd low cycle of pulse 2 -> interrupt_acknowledge_n=1 and state IDLE at that edge; no vector_valid; outputs at reset values.
- INT dropped after pulse 1 and mode_8086 toggled mid-sequence -> all pulses of the latched mode complete, vector_valid issued; INT held high throughout -> next sequence begins 2 cycles after vector_valid.
